id_pipe_stage: RTL
==================

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 Parameter OPW, default 4, opcode field width.
REQ-002 Parameter DW, default 8, operand/data width.
REQ-003 Parameter RAW, default 3, register address width; register file depth 2**RAW; RAW SHALL be <= DW.
REQ-004 Derived IW = OPW+2+2*DW (default 22); instr layout {opcode[OPW], ma, mb, fa[DW], fb[DW]}, MSB first.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  instr is valid.
REQ-008 in_ready  output  1  stage can accept instr this cycle.
REQ-009 instr  input  IW  instruction word.
REQ-010 out_valid  output  1  decoded outputs are valid.
REQ-011 out_ready  input  1  downstream accepts decoded outputs.
REQ-012 opcode_o  output  OPW  decoded opcode.
REQ-013 a_o  output  DW  resolved operand A.
REQ-014 b_o  output  DW  resolved operand B.
REQ-015 wb_en  input  1  register-file write enable.
REQ-016 wb_addr  input  RAW  write address.
REQ-017 wb_data  input  DW  write data.
REQ-018 dec_cnt  output  16  count of decoded words handed downstream.

Function
REQ-019 Accept on in_valid & in_ready; deliver on out_valid & out_ready.
REQ-020 Operand resolution at accept: ma=0 -> a_o = fa (immediate); ma=1 -> a_o = regfile[fa[RAW-1:0]]; same rule for mb/fb/b_o; fa/fb bits above RAW ignored in register mode.
REQ-021 Write-through bypass: wb_en in the accept cycle with wb_addr equal to a register-mode index -> operand takes wb_data, not the stale entry.
REQ-022 Register file: written on rising edge when wb_en=1; writes independent of handshake state.
REQ-023 Latency: word accepted in cycle N is on the outputs with out_valid=1 in cycle N+1 when the output register is empty or draining.
REQ-024 Buffering: output register plus one skid register; throughput one word per cycle with out_ready held high.
REQ-025 in_ready = NOT skid_valid (registered, no combinational path from out_ready to in_ready).
REQ-026 States: EMPTY (no valid), ONE (output valid), FULL (output + skid valid).
REQ-027 EMPTY -> ONE on accept; ONE -> EMPTY on deliver without accept; ONE stays ONE on accept and deliver together; ONE -> FULL on accept without deliver; FULL -> ONE on deliver (skid moves to output); no accept in FULL.
REQ-028 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Order preserved: words delivered in acceptance order, none dropped or duplicated.
REQ-030 Skid entry holds operands resolved at its own accept; later writebacks do not alter it.
REQ-031 dec_cnt increments by 1 per deliver; wraps 16'hFFFF -> 0.
REQ-032 Opcode passes through unmodified; no opcode is treated as illegal.

Reset
REQ-033 On rst=1, immediately: out_valid=0, skid empty, state EMPTY, opcode_o/a_o/b_o=0, dec_cnt=0, all register-file entries=0.
REQ-034 Reset mid-operation discards buffered words; no deliver in the reset cycle.
REQ-035 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-036 Immediate mode: instr {4'h3,0,0,8'h5A,8'hC3}, out_ready=1 -> next cycle out_valid=1, opcode_o=3, a_o=5A, b_o=C3, dec_cnt=1.
REQ-037 Register mode: write r2=8'h11, r5=8'h22; then instr {4'h7,1,1,8'h02,8'hF5} -> a_o=11, b_o=22 (F5 indexes r5).
REQ-038 Bypass: accept instr reading r4 (ma=1) in the same cycle as wb_en, wb_addr=4, wb_data=8'h99 -> a_o=99.
REQ-039 Backpressure: out_ready=0, three words offered back to back -> first two accepted, in_ready=0 on third; outputs hold; release out_ready -> words delivered in order, dec_cnt=2 after both.
REQ-040 Streaming: 100 words with in_valid and out_ready held high -> one deliver per cycle after one-cycle latency, dec_cnt=100.
REQ-041 Reset in FULL -> out_valid=0, dec_cnt=0, register reads return 0, in_ready=1 after release.

Source files
------------

// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage: resolves two operands (immediate or register-file
// read with write-through bypass) and hands them downstream through an output + skid buffer.
module id_pipe_stage #(
  parameter int OPW = 4,
  parameter int DW  = 8,
  parameter int RAW = 3,
  localparam int IW = OPW + 2 + 2*DW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  instr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] opcode_o,
  output logic [DW-1:0]  a_o,
  output logic [DW-1:0]  b_o,
  input  logic           wb_en,
  input  logic [RAW-1:0] wb_addr,
  input  logic [DW-1:0]  wb_data,
  output logic [15:0]    dec_cnt
);

  localparam int DEPTH = 2**RAW;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_reg, state_next;

  logic [OPW-1:0] f_op;
  logic           f_ma, f_mb;
  logic [DW-1:0]  f_a, f_b;
  logic [DW-1:0]  res_a, res_b;

  logic [DW-1:0]  rf_reg [DEPTH];

  logic [OPW-1:0] out_op_reg, skid_op_reg;
  logic [DW-1:0]  out_a_reg, out_b_reg, skid_a_reg, skid_b_reg;
  logic [15:0]    dec_cnt_reg;

  logic accept, deliver;
  logic load_out, out_from_skid, load_skid;

  assign f_op = instr[IW-1 -: OPW];
  assign f_ma = instr[2*DW+1];
  assign f_mb = instr[2*DW];
  assign f_a  = instr[2*DW-1 -: DW];
  assign f_b  = instr[DW-1:0];

  // Both flags come straight from the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // Register file: each entry has its own clear and write strobe.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rf
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          rf_reg[gi] <= '0;
        else if (wb_en && (wb_addr == RAW'(gi)))
          rf_reg[gi] <= wb_data;
      end
    end
  endgenerate

  // Operand resolution; a same-cycle writeback to the read index wins over the stored entry.
  always_comb begin
    res_a = f_a;
    res_b = f_b;
    if (f_ma)
      res_a = (wb_en && (wb_addr == f_a[RAW-1:0])) ? wb_data : rf_reg[f_a[RAW-1:0]];
    if (f_mb)
      res_b = (wb_en && (wb_addr == f_b[RAW-1:0])) ? wb_data : rf_reg[f_b[RAW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= EMPTY;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          load_out   = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (deliver) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          state_next    = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_op_reg  <= '0;
      out_a_reg   <= '0;
      out_b_reg   <= '0;
      skid_op_reg <= '0;
      skid_a_reg  <= '0;
      skid_b_reg  <= '0;
      dec_cnt_reg <= '0;
    end else begin
      if (load_out) begin
        if (out_from_skid) begin
          out_op_reg <= skid_op_reg;
          out_a_reg  <= skid_a_reg;
          out_b_reg  <= skid_b_reg;
        end else begin
          out_op_reg <= f_op;
          out_a_reg  <= res_a;
          out_b_reg  <= res_b;
        end
      end
      if (load_skid) begin
        skid_op_reg <= f_op;
        skid_a_reg  <= res_a;
        skid_b_reg  <= res_b;
      end
      if (deliver)
        dec_cnt_reg <= dec_cnt_reg + 16'd1;
    end
  end

  assign opcode_o = out_op_reg;
  assign a_o      = out_a_reg;
  assign b_o      = out_b_reg;
  assign dec_cnt  = dec_cnt_reg;

endmodule
